// File: rtl/bp_encode_scheduler_if.sv
// Group-descriptor and encoder-control bundle for bp_encode_scheduler.
// master = scheduler side, slave = upstream/encoder side.
interface bp_encode_scheduler_if #(
  parameter int NUM_COMP = 3
);
  logic                grp_valid;
  logic                grp_ready;
  logic [1:0]          grp_ecgidx;
  logic [1:0]          grp_sub_sample;
  logic [NUM_COMP-1:0] grp_comp_mask;
  logic                enc_load;
  logic [1:0]          enc_component_idx;
  logic [1:0]          enc_ecgidx;
  logic [1:0]          enc_sub_sample_info;
  logic                enc_component_skip;
  logic                enc_underflow_prevention;
  logic                enc_valid_op;
  logic [5:0]          enc_size;

  modport master (
    input  grp_valid, grp_ecgidx, grp_sub_sample, grp_comp_mask, enc_valid_op, enc_size,
    output grp_ready, enc_load, enc_component_idx, enc_ecgidx, enc_sub_sample_info,
           enc_component_skip, enc_underflow_prevention
  );

  modport slave (
    output grp_valid, grp_ecgidx, grp_sub_sample, grp_comp_mask, enc_valid_op, enc_size,
    input  grp_ready, enc_load, enc_component_idx, enc_ecgidx, enc_sub_sample_info,
           enc_component_skip, enc_underflow_prevention
  );
endinterface

// File: rtl/bp_encode_scheduler.sv
// BP-mode ECG encode scheduler: issues each component of a group and models rate-buffer fill.
// Optional WAIT watchdog enabled by defining BPS_TIMEOUT_EN.
module bp_encode_scheduler #(
  parameter int NUM_COMP   = 3,
  parameter int BUF_SIZE   = 4096,
  parameter int DRAIN_BITS = 32,
  parameter int UF_THRESH  = 256,
  parameter int HEADROOM   = 150
`ifdef BPS_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  bp_encode_scheduler_if.master         bus,
  input  logic                          drain_en,
  output logic [$clog2(BUF_SIZE+1)-1:0] fullness,
  output logic                          grp_done,
  output logic                          overflow,
  output logic                          timeout_err
);
  localparam int FW = $clog2(BUF_SIZE+1);
  localparam logic signed [FW:0] BUF_S   = (FW+1)'(BUF_SIZE);
  localparam logic signed [FW:0] DRAIN_S = (FW+1)'(DRAIN_BITS);
  localparam logic [FW-1:0]      BUF_U   = FW'(BUF_SIZE);
  localparam logic [FW-1:0]      RDY_LIM = FW'(BUF_SIZE - HEADROOM);
  localparam logic [FW-1:0]      UF_LIM  = FW'(UF_THRESH);
  localparam logic [1:0]         LAST    = 2'(NUM_COMP - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} st_e;

  st_e                 st_q, st_d;
  logic [1:0]          comp_q, comp_d;
  logic [1:0]          ecg_q, ecg_d;
  logic [1:0]          sub_q, sub_d;
  logic [NUM_COMP-1:0] mask_q, mask_d;
  logic                skip_q, skip_d;
  logic                upf_q, upf_d;
  logic [FW-1:0]       full_q, full_d;
  logic                rdy_q;
  logic                ovf_q, ovf_set;
  logic signed [FW:0]  sum;
  logic                tmo_hit;
  logic                adv;

`ifdef BPS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] tmo_q;
  logic          terr_q;

  // A timeout only fires when the encoder stays silent in the limit cycle.
  assign tmo_hit = (st_q == WAIT) && !bus.enc_valid_op && (tmo_q == TW'(TIMEOUT_CYC-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      if (st_q == ISSUE)     tmo_q <= '0;
      else if (st_q == WAIT) tmo_q <= tmo_q + TW'(1);
      if (tmo_hit)           terr_q <= 1'b1;
    end
  end
  assign timeout_err = terr_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign adv = bus.enc_valid_op || tmo_hit;

  // Add/drain in one signed expression, then clamp into [0, BUF_SIZE].
  always_comb begin
    sum = $signed({1'b0, full_q});
    if (st_q == WAIT && bus.enc_valid_op) sum = sum + $signed({{(FW-5){1'b0}}, bus.enc_size});
    if (drain_en) sum = sum - DRAIN_S;
    ovf_set = 1'b0;
    full_d  = full_q;
    if (sum[FW]) begin
      full_d = '0;
    end else if (sum > BUF_S) begin
      full_d  = BUF_U;
      ovf_set = 1'b1;
    end else begin
      full_d = sum[FW-1:0];
    end
  end

  always_comb begin
    st_d   = st_q;
    comp_d = comp_q;
    ecg_d  = ecg_q;
    sub_d  = sub_q;
    mask_d = mask_q;
    case (st_q)
      IDLE: if (bus.grp_valid && rdy_q) begin
        ecg_d  = bus.grp_ecgidx;
        sub_d  = bus.grp_sub_sample;
        mask_d = bus.grp_comp_mask;
        comp_d = '0;
        st_d   = ISSUE;
      end
      ISSUE: st_d = WAIT;
      WAIT: if (adv) begin
        if (comp_q == LAST) begin
          st_d = DONE;
        end else begin
          comp_d = comp_q + 2'd1;
          st_d   = ISSUE;
        end
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Per-component controls are captured on entry to ISSUE so they hold through WAIT.
  always_comb begin
    skip_d = skip_q;
    upf_d  = upf_q;
    if (st_d == ISSUE && st_q != ISSUE) begin
      skip_d = ~mask_d[comp_d];
      upf_d  = full_d < UF_LIM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      comp_q <= '0;
      ecg_q  <= '0;
      sub_q  <= '0;
      mask_q <= '0;
      skip_q <= 1'b0;
      upf_q  <= 1'b0;
      full_q <= '0;
      rdy_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      comp_q <= comp_d;
      ecg_q  <= ecg_d;
      sub_q  <= sub_d;
      mask_q <= mask_d;
      skip_q <= skip_d;
      upf_q  <= upf_d;
      full_q <= full_d;
      rdy_q  <= (st_d == IDLE) && (full_q <= RDY_LIM);
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign bus.grp_ready                = rdy_q;
  assign bus.enc_load                 = (st_q == ISSUE);
  assign bus.enc_component_idx        = comp_q;
  assign bus.enc_ecgidx               = ecg_q;
  assign bus.enc_sub_sample_info      = sub_q;
  assign bus.enc_component_skip       = skip_q;
  assign bus.enc_underflow_prevention = upf_q;
  assign fullness                     = full_q;
  assign grp_done                     = (st_q == DONE);
  assign overflow                     = ovf_q;
endmodule

// File: tb/tb_bp_encode_scheduler.sv
// Directed bench for bp_encode_scheduler; HEADROOM is shortened to 100 so the
// clamp-at-BUF_SIZE path is reachable with legal encoder sizes (0..50).
module tb_bp_encode_scheduler;
  localparam int NC = 3;
  localparam int BS = 4096;
  localparam int DB = 32;
  localparam int UF = 256;
  localparam int HR = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        drain_en = 1'b0;
  logic [12:0] fullness;
  logic        grp_done, overflow, timeout_err;

  bp_encode_scheduler_if #(.NUM_COMP(NC)) bus();

  bp_encode_scheduler #(.NUM_COMP(NC), .HEADROOM(HR)) dut (
    .clk(clk), .rst(rst), .bus(bus), .drain_en(drain_en), .fullness(fullness),
    .grp_done(grp_done), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fm    = 0;
  int gid   = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fm_upd(input int add, input bit drn);
    fm = fm + add - (drn ? DB : 0);
    if (fm < 0)  fm = 0;
    if (fm > BS) fm = BS;
  endtask

  task automatic start_grp(input logic [1:0] ecg, input logic [1:0] sub, input logic [2:0] mask);
    int w;
    w = 0;
    while (!bus.grp_ready && w < 300) begin step; w++; end
    chk("start rdy", bus.grp_ready, 1);
    bus.grp_ecgidx = ecg; bus.grp_sub_sample = sub; bus.grp_comp_mask = mask;
    bus.grp_valid = 1'b1;
    step;
    bus.grp_valid = 1'b0;
    chk("start load", bus.enc_load, 1);
  endtask

  // One whole group; encoder answers lat cycles after each enc_load.
  task automatic run_grp(input string tag, input logic [2:0] mask, input int lat,
                         input int s0, input int s1, input int s2, input bit drn_last,
                         input int exp_full);
    int sz[3];
    int cyc, w;
    logic [1:0] ecg, sub;
    sz  = '{s0, s1, s2};
    ecg = gid[1:0];
    sub = gid[3:2];
    gid++;
    w = 0;
    while (!bus.grp_ready && w < 300) begin step; w++; end
    chk({tag, " rdy"}, bus.grp_ready, 1);
    bus.grp_ecgidx = ecg; bus.grp_sub_sample = sub; bus.grp_comp_mask = mask;
    bus.grp_valid = 1'b1;
    cyc = 1;
    step; cyc++;
    bus.grp_valid = 1'b0;
    chk({tag, " lat1"}, cyc, 2);
    for (int c = 0; c < NC; c++) begin
      w = 0;
      while (!bus.enc_load && w < 20) begin step; cyc++; w++; end
      chk($sformatf("%s c%0d load", tag, c), bus.enc_load, 1);
      chk($sformatf("%s c%0d idx", tag, c), bus.enc_component_idx, c);
      chk($sformatf("%s c%0d ecg", tag, c), bus.enc_ecgidx, ecg);
      chk($sformatf("%s c%0d sub", tag, c), bus.enc_sub_sample_info, sub);
      chk($sformatf("%s c%0d skip", tag, c), bus.enc_component_skip, !mask[c]);
      chk($sformatf("%s c%0d upf", tag, c), bus.enc_underflow_prevention, fm < UF);
      chk($sformatf("%s c%0d rdy", tag, c), bus.grp_ready, 0);
      repeat (lat) begin step; cyc++; end
      chk($sformatf("%s c%0d hold", tag, c), {bus.enc_component_idx, bus.enc_component_skip},
          {c[1:0], !mask[c]});
      bus.enc_valid_op = 1'b1;
      bus.enc_size = 6'(sz[c]);
      drain_en = drn_last && (c == NC-1);
      fm_upd(sz[c], drain_en);
      step; cyc++;
      bus.enc_valid_op = 1'b0;
      bus.enc_size = '0;
      drain_en = 1'b0;
    end
    chk({tag, " done"}, grp_done, 1);
    chk({tag, " done_cyc"}, cyc, NC*(1+lat)+2);
    chk({tag, " full"}, fullness, fm);
    if (exp_full >= 0) chk({tag, " full_hand"}, fullness, exp_full);
    step;
    chk({tag, " done1"}, grp_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.grp_valid = 1'b0; bus.grp_ecgidx = '0; bus.grp_sub_sample = '0; bus.grp_comp_mask = '0;
    bus.enc_valid_op = 1'b0; bus.enc_size = '0;
    repeat (3) step;
    chk("rst rdy", bus.grp_ready, 0);
    chk("rst load", bus.enc_load, 0);
    chk("rst ctl", {bus.enc_component_idx, bus.enc_ecgidx, bus.enc_sub_sample_info,
                    bus.enc_component_skip, bus.enc_underflow_prevention}, 0);
    chk("rst full", fullness, 0);
    chk("rst flags", {grp_done, overflow, timeout_err}, 0);
    rst = 1'b1;
    step;
    chk("rel rdy", bus.grp_ready, 1);

    // valid_op outside WAIT must not touch fullness or the FSM
    bus.enc_valid_op = 1'b1; bus.enc_size = 6'd30;
    step;
    bus.enc_valid_op = 1'b0; bus.enc_size = '0;
    chk("idle vop full", fullness, 0);
    chk("idle vop load", bus.enc_load, 0);

    run_grp("A",   3'b111, 2, 20, 30, 40, 1'b0, 90);
    run_grp("B",   3'b101, 1,  5,  0,  5, 1'b0, 100);
    run_grp("UP1", 3'b111, 1,  0,  0,  0, 1'b0, 100);
    run_grp("F1",  3'b111, 1, 50, 50, 50, 1'b0, 250);
    run_grp("F2",  3'b011, 3, 50,  0,  0, 1'b0, 300);
    run_grp("UP0", 3'b111, 1,  0,  0,  0, 1'b0, 300);
    for (int i = 0; i < 24; i++) run_grp("FILL", 3'b111, 1, 50, 50, 50, 1'b0, -1);
    run_grp("F3",  3'b111, 1, 50, 50, 22, 1'b0, 4022);

    // 4022 > 4096-100: upstream is held off
    bus.grp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hr rdy", bus.grp_ready, 0);
      step;
      chk("hr load", bus.enc_load, 0);
    end
    bus.grp_valid = 1'b0;
    drain_en = 1'b1;
    step;
    drain_en = 1'b0;
    fm = 3990;
    chk("hr drain", fullness, 3990);
    chk("hr rdy lag", bus.grp_ready, 0);
    step;
    chk("hr rdy up", bus.grp_ready, 1);
    chk("ovf pre", overflow, 0);

    // 4090 + 50 - 32 = 4108, clamped
    run_grp("OVF", 3'b111, 1, 50, 50, 50, 1'b1, 4096);
    chk("ovf set", overflow, 1);

    drain_en = 1'b1;
    repeat (130) step;
    drain_en = 1'b0;
    fm = 0;
    chk("drain zero", fullness, 0);
    chk("ovf sticky", overflow, 1);

    run_grp("TEN", 3'b111, 1, 10, 0, 0, 1'b0, 10);
    drain_en = 1'b1;
    step;
    drain_en = 1'b0;
    fm = 0;
    chk("neg clamp", fullness, 0);
    run_grp("PRE", 3'b111, 2, 30, 0, 0, 1'b0, 30);

`ifdef BPS_TIMEOUT_EN
    start_grp(2'b11, 2'b10, 3'b010);
    chk("tmo err0", timeout_err, 0);
    step;
    w = 1;
    while (!bus.enc_load && w < 200) begin step; w++; end
    chk("tmo gap", w, 65);
    chk("tmo err", timeout_err, 1);
    chk("tmo idx", bus.enc_component_idx, 1);
    chk("tmo full", fullness, 30);
    step;
`else
    chk("tmo tied", timeout_err, 0);
    start_grp(2'b11, 2'b10, 3'b010);
    w = 0;
    chk("abort skip", bus.enc_component_skip, 1);
    step;
`endif

    // asynchronous abort mid-WAIT
    rst = 1'b0;
    #1;
    chk("abort load", bus.enc_load, 0);
    chk("abort ctl", {bus.enc_component_idx, bus.enc_ecgidx, bus.enc_sub_sample_info,
                      bus.enc_component_skip, bus.enc_underflow_prevention}, 0);
    chk("abort rdy", bus.grp_ready, 0);
    chk("abort full", fullness, 0);
    chk("abort flags", {grp_done, overflow, timeout_err}, 0);
    step;
    rst = 1'b1;
    step;
    chk("post rdy", bus.grp_ready, 1);
    chk("post done", grp_done, 0);
    chk("post load", bus.enc_load, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
